// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM bus.
// slave: arbiter side, master: requesters and RAM side.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_done_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;
    logic                  if_stall_o;

    logic                  mem_req_i;
    logic [3:0]            mem_op_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [DATA_WIDTH-1:0] mem_data_i;
    logic                  mem_done_o;
    logic [DATA_WIDTH-1:0] mem_rdata_o;
    logic                  mem_stall_o;

    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic                  ram_we_o;
    logic [DATA_WIDTH-1:0] ram_data_o;
    logic [DATA_WIDTH-1:0] ram_data_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_op_i, mem_addr_i, mem_data_i,
        input  ram_data_i,
        output if_done_o, if_rdata_o, if_stall_o,
        output mem_done_o, mem_rdata_o, mem_stall_o,
        output ram_addr_o, ram_we_o, ram_data_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_op_i, mem_addr_i, mem_data_i,
        output ram_data_i,
        input  if_done_o, if_rdata_o, if_stall_o,
        input  mem_done_o, mem_rdata_o, mem_stall_o,
        input  ram_addr_o, ram_we_o, ram_data_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data RAM sequencer/arbiter: IF vs MEM, word R/W and SB/SH RMW.
// Optional macro DMEM_ARB_RR_EN selects round-robin arbitration.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dmem_arbiter_if.slave bus
);
    // Store encodings; every other op code is a word read.
    localparam logic [3:0] OP_SB = 4'h8;
    localparam logic [3:0] OP_SH = 4'h9;
    localparam logic [3:0] OP_SW = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_RMW,
        S_ACK
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner_mem;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_op;
    logic [15:0]           r_data;

    logic                  w_any;
    logic                  w_grant_mem;
    logic                  w_is_sw;
    logic                  w_is_sub;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [DATA_WIDTH-1:0] w_merge;

    assign w_any = bus.if_req_i | bus.mem_req_i;

`ifdef DMEM_ARB_RR_EN
    logic r_last_mem;

    assign w_grant_mem = bus.mem_req_i &
                         (~bus.if_req_i | ~r_last_mem);

    // Remember which port won the most recent grant.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_last_mem <= 1'b0;
        end else if (r_state == S_IDLE && w_any) begin
            r_last_mem <= w_grant_mem;
        end
    end
`else
    assign w_grant_mem = bus.mem_req_i;
`endif

    assign w_is_sw  = (bus.mem_op_i == OP_SW);
    assign w_is_sub = (bus.mem_op_i == OP_SB) ||
                      (bus.mem_op_i == OP_SH);

    assign w_req_addr = w_grant_mem ? bus.mem_addr_i
                                    : bus.if_addr_i;
    assign w_word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch owner, address, op and sub-word data on each grant.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_owner_mem <= 1'b0;
            r_addr      <= '0;
            r_op        <= '0;
            r_data      <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_owner_mem <= w_grant_mem;
            r_addr      <= w_req_addr;
            r_op        <= bus.mem_op_i;
            r_data      <= bus.mem_data_i[15:0];
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (!w_grant_mem) begin
                        w_next = S_RD;
                    end else if (w_is_sw) begin
                        w_next = S_ACK;
                    end else if (w_is_sub) begin
                        w_next = S_RMW;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD:  w_next = S_IDLE;
            S_RMW: w_next = S_ACK;
            S_ACK: w_next = S_IDLE;
        endcase
    end

    // Splice the new byte or half into the word just read back.
    always_comb begin
        w_merge = bus.ram_data_i;
        if (r_op == OP_SB) begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_data[7:0];
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_data;
        end else begin
            w_merge[15:0] = r_data;
        end
    end

    // Outputs; everything is held at 0 while reset is asserted.
    always_comb begin
        bus.if_done_o   = 1'b0;
        bus.if_rdata_o  = '0;
        bus.mem_done_o  = 1'b0;
        bus.mem_rdata_o = '0;
        bus.ram_addr_o  = '0;
        bus.ram_we_o    = 1'b0;
        bus.ram_data_o  = '0;
        if (rst_i) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        bus.ram_addr_o =
                            {w_req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (w_grant_mem && w_is_sw) begin
                            bus.ram_we_o   = 1'b1;
                            bus.ram_data_o = bus.mem_data_i;
                        end
                    end
                end
                S_RD: begin
                    bus.ram_addr_o = w_word_addr;
                    if (r_owner_mem) begin
                        bus.mem_done_o  = 1'b1;
                        bus.mem_rdata_o = bus.ram_data_i;
                    end else begin
                        bus.if_done_o  = 1'b1;
                        bus.if_rdata_o = bus.ram_data_i;
                    end
                end
                S_RMW: begin
                    bus.ram_addr_o = w_word_addr;
                    bus.ram_we_o   = 1'b1;
                    bus.ram_data_o = w_merge;
                end
                S_ACK: begin
                    bus.mem_done_o = 1'b1;
                end
            endcase
        end
    end

    assign bus.if_stall_o  = rst_i & bus.if_req_i & ~bus.if_done_o;
    assign bus.mem_stall_o = rst_i & bus.mem_req_i & ~bus.mem_done_o;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a synchronous RAM model.
// Build with +define+DMEM_ARB_RR_EN to check round-robin grants.
module tb_dmem_arbiter;
    localparam logic [3:0] T_LB = 4'h0;
    localparam logic [3:0] T_LW = 4'h2;
    localparam logic [3:0] T_SB = 4'h8;
    localparam logic [3:0] T_SH = 4'h9;
    localparam logic [3:0] T_SW = 4'hA;

    typedef struct {
        logic [31:0] d;
        bit          chk;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t q_if[$];
    exp_t q_mem[$];
    bit   ord[$];
    bit   log_ord = 0;
    bit   we_forbid = 0;
    bit   stall_watch = 0;

    logic [31:0] ram [0:63];
    logic [31:0] ram_rd;
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    dmem_arbiter_if bus ();

    dmem_arbiter u_dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pre_we) ram[pre_idx] <= pre_data;
        else if (bus.ram_we_o) ram[bus.ram_addr_o[7:2]] <= bus.ram_data_o;
        ram_rd <= ram[bus.ram_addr_o[7:2]];
    end
    assign bus.ram_data_i = ram_rd;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h", name, act, req);
        end
    endtask

    task automatic pop_cmp(input bit is_mem, input logic [31:0] rd);
        exp_t e;
        string p;
        p = is_mem ? "mem" : "if";
        if (is_mem ? (q_mem.size() == 0) : (q_if.size() == 0)) begin
            check({p, "_done_unexpected"}, 32'd1, 32'd0);
        end else begin
            e = is_mem ? q_mem.pop_front() : q_if.pop_front();
            check({p, "_done_cycle"}, cyc, e.cyc);
            if (e.chk) check({p, "_rdata"}, rd, e.d);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.if_done_o) begin
                pop_cmp(1'b0, bus.if_rdata_o);
                if (log_ord) ord.push_back(1'b0);
            end
            if (bus.mem_done_o) begin
                pop_cmp(1'b1, bus.mem_rdata_o);
                if (log_ord) ord.push_back(1'b1);
            end
            if (we_forbid) check("fetch_we", bus.ram_we_o, 1'b0);
            if (stall_watch) check("if_stall_held", bus.if_stall_o, 1'b1);
            check("ram_addr_align", bus.ram_addr_o & 32'h3, 32'h0);
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_idx = addr[7:2];
        pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic wait_done(input bit is_mem, input string name);
        bit got;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = is_mem ? bus.mem_done_o : bus.if_done_o;
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic access(input bit is_mem, input logic [3:0] op,
                          input logic [31:0] addr, input logic [31:0] d,
                          input bit chk, input logic [31:0] ed,
                          input int lat);
        @(posedge clk);
        #1;
        if (is_mem) begin
            bus.mem_req_i = 1'b1;
            bus.mem_op_i = op;
            bus.mem_addr_i = addr;
            bus.mem_data_i = d;
            q_mem.push_back('{ed, chk, cyc + lat});
        end else begin
            bus.if_req_i = 1'b1;
            bus.if_addr_i = addr;
            q_if.push_back('{ed, chk, cyc + lat});
        end
        wait_done(is_mem, is_mem ? "mem" : "if");
    endtask

    task automatic drop();
        @(posedge clk);
        #1;
        bus.if_req_i = 1'b0;
        bus.mem_req_i = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_we"}, bus.ram_we_o, 1'b0);
        check({name, "_addr"}, bus.ram_addr_o, 32'h0);
        check({name, "_wdata"}, bus.ram_data_o, 32'h0);
        check({name, "_done"}, {bus.if_done_o, bus.mem_done_o}, 2'b00);
        check({name, "_rdata"}, bus.if_rdata_o | bus.mem_rdata_o, 32'h0);
        check({name, "_stall"}, {bus.if_stall_o, bus.mem_stall_o}, 2'b00);
    endtask

    bit exp_ord [3];
    int nd;

    initial begin
        bus.if_req_i = 1'b0;
        bus.if_addr_i = '0;
        bus.mem_req_i = 1'b0;
        bus.mem_op_i = T_LW;
        bus.mem_addr_i = '0;
        bus.mem_data_i = '0;

        preload(32'h10, 32'hDEADBEEF);
        preload(32'h20, 32'h11223344);
        preload(32'h40, 32'h00000000);
        preload(32'h50, 32'hA5A5A5A5);
        preload(32'h54, 32'h5A5A5A5A);

        // Requests during reset must not leak to the outputs.
        bus.if_req_i = 1'b1;
        bus.if_addr_i = 32'h10;
        #1 check_quiet("reset");
        bus.if_req_i = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        we_forbid = 1;
        access(0, T_LW, 32'h10, 0, 1, 32'hDEADBEEF, 1);
        drop();
        we_forbid = 0;

        access(1, T_SB, 32'h22, 32'h000000AA, 0, 0, 2);
        drop();
        check("sb_ram", ram[8], 32'h11AA3344);
        access(1, T_SH, 32'h23, 32'h0000BEEF, 0, 0, 2);
        drop();
        check("sh_ram", ram[8], 32'hBEEF3344);
        access(1, T_LB, 32'h21, 0, 1, 32'hBEEF3344, 1);
        drop();

        access(1, T_SW, 32'h30, 32'hCAFEF00D, 0, 0, 1);
        access(1, T_LW, 32'h30, 0, 1, 32'hCAFEF00D, 1);
        drop();
        access(1, T_SW, 32'h33, 32'h12345678, 0, 0, 1);
        drop();
        check("sw_unaligned_ram", ram[12], 32'h12345678);

        // Last grant is IF before the conflict burst.
        access(0, T_LW, 32'h10, 0, 1, 32'hDEADBEEF, 1);
        drop();

        @(posedge clk);
        #1;
        bus.if_req_i = 1'b1;
        bus.if_addr_i = 32'h50;
        bus.mem_req_i = 1'b1;
        bus.mem_op_i = T_LW;
        bus.mem_addr_i = 32'h54;
        log_ord = 1;
`ifdef DMEM_ARB_RR_EN
        exp_ord = '{1'b1, 1'b0, 1'b1};
        q_mem.push_back('{32'h5A5A5A5A, 1, cyc + 1});
        q_if.push_back('{32'hA5A5A5A5, 1, cyc + 3});
        q_mem.push_back('{32'h5A5A5A5A, 1, cyc + 5});
`else
        exp_ord = '{1'b1, 1'b1, 1'b1};
        stall_watch = 1;
        q_mem.push_back('{32'h5A5A5A5A, 1, cyc + 1});
        q_mem.push_back('{32'h5A5A5A5A, 1, cyc + 3});
        q_mem.push_back('{32'h5A5A5A5A, 1, cyc + 5});
`endif
        nd = 0;
        for (int k = 0; k < 20 && nd < 3; k++) begin
            @(negedge clk);
            nd += int'(bus.if_done_o) + int'(bus.mem_done_o);
        end
        check("conflict_dones", nd, 3);
        drop();
        log_ord = 0;
        stall_watch = 0;
        check("grant_count", ord.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < ord.size())
                check($sformatf("grant_%0d", i), ord[i], exp_ord[i]);
        end

        // Reset in the RMW cycle must suppress the write.
        @(posedge clk);
        #1;
        bus.mem_req_i = 1'b1;
        bus.mem_op_i = T_SB;
        bus.mem_addr_i = 32'h40;
        bus.mem_data_i = 32'h000000FF;
        @(posedge clk);
        #1 check("rmw_we_before_rst", bus.ram_we_o, 1'b1);
        rst_n = 1'b0;
        #1 check("rmw_rst_we", bus.ram_we_o, 1'b0);
        check("rmw_rst_addr", bus.ram_addr_o, 32'h0);
        check("rmw_rst_wdata", bus.ram_data_o, 32'h0);
        check("rmw_rst_done", bus.mem_done_o, 1'b0);
        check("rmw_rst_stall", bus.mem_stall_o, 1'b0);
        bus.mem_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check("rmw_rst_ram", ram[16], 32'h00000000);
        @(negedge clk);
        check_quiet("post_rst");

        // First conflict after reset goes to MEM, then IF.
        @(posedge clk);
        #1;
        bus.if_req_i = 1'b1;
        bus.if_addr_i = 32'h50;
        bus.mem_req_i = 1'b1;
        bus.mem_op_i = T_LW;
        bus.mem_addr_i = 32'h54;
        q_mem.push_back('{32'h5A5A5A5A, 1, cyc + 1});
        q_if.push_back('{32'hA5A5A5A5, 1, cyc + 3});
        wait_done(1, "post_rst_mem");
        @(posedge clk);
        #1 bus.mem_req_i = 1'b0;
        wait_done(0, "post_rst_if");
        drop();

        repeat (3) @(posedge clk);
        check("q_if_empty", q_if.size(), 0);
        check("q_mem_empty", q_mem.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and arbiter for the single-port data RAM, placed between the RAM and its two requesters: the instruction-fetch port and the MEM stage. It grants one request per access and sequences word reads, word writes, and two-cycle read-modify-write for SB/SH. It also returns completion pulses that the pipeline uses as stall release. Sub-word load extraction stays in the MEM stage; this block always returns the raw 32-bit word.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, RAM word width (fixed at 32; byte lanes assume 4 bytes)

- clk_i  in  1  single clock; all state changes on rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_done_o
- if_addr_i  in  ADDR_WIDTH  fetch byte address
- if_done_o  out  1  fetch complete; if_rdata_o valid this cycle
- if_rdata_o  out  DATA_WIDTH  fetched word
- mem_req_i  in  1  MEM-stage request, held until mem_done_o
- mem_op_i  in  4  `LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW from defines.v
- mem_addr_i  in  ADDR_WIDTH  data byte address
- mem_data_i  in  DATA_WIDTH  store data; low byte/half used for SB/SH
- mem_done_o  out  1  MEM access complete
- mem_rdata_o  out  DATA_WIDTH  loaded word, valid with mem_done_o on loads
- if_stall_o / mem_stall_o  out  1  req_i & ~done_o, per port
- ram_addr_o  out  ADDR_WIDTH  word-aligned address ([1:0]=0)
- ram_we_o  out  1  write strobe, committed at clock edge
- ram_data_o  out  DATA_WIDTH  write word
- ram_data_i  in  DATA_WIDTH  read word, valid one cycle after address

## Operation
- States: IDLE, RD, RMW, ACK. Reset state is IDLE.
- IDLE with no request: ram_we_o=0, ram_addr_o=0, and all done outputs are 0.
- IDLE with any request: pick a winner; latch owner, address and op; drive ram_addr_o = {addr[ADDR_WIDTH-1:2],2'b00} combinationally.
  - Loads and fetch go to RD.
  - `SW: ram_we_o=1, ram_data_o=mem_data_i, then go to ACK.
  - `SB/`SH: go to RMW.
- RD: the owner's done=1 and rdata_o=ram_data_i; next state IDLE.
- RMW: merge the old word from ram_data_i with the new data, assert ram_we_o=1 at the latched address, go to ACK.
  - SB writes byte lane addr[1:0].
  - SH writes half lane addr[1]; addr[0] is ignored.
- ACK: mem_done_o=1; next state IDLE.
- Any mem_op_i outside the store set is a word read. SW ignores addr[1:0].
- Default arbitration is fixed priority: MEM beats IF.
- Requesters drop req in the cycle after done. A req still high in that IDLE cycle is a new request.

## Timing
- Reset (async, immediate) drives every output to 0: state=IDLE, done outputs, ram_we_o, ram_addr_o, ram_data_o, rdata outputs; last-grant flag = IF.
- Reset during RMW aborts before the write edge, so the RAM word is unchanged.
- Latencies with req at cycle N:
  - fetch/load done at N+1
  - SW written at the N edge, done at N+1
  - SB/SH done at N+2, written at the N+1 edge
- Next grant happens no earlier than the cycle after done, giving 1 idle-grant cycle per access. Throughput is 1 read per 2 cycles.
- A simultaneous IF and MEM request in IDLE grants one port. The loser's stall stays high and it is granted at the next IDLE.
- Requests arriving while state≠IDLE are not sampled.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On conflict, the port not granted last wins. The last-grant flag updates on every grant, and the first conflict after reset goes to MEM.
- Undefined: fixed MEM-over-IF priority; no last-grant flag.

## Test plan
- Fetch only: RAM[0x10]=0xDEADBEEF, if_req at N with addr 0x10 -> if_done_o=1 and if_rdata_o=0xDEADBEEF at N+1; ram_we_o=0 throughout.
- SB: RAM[0x20]=0x11223344, SB addr 0x22 data 0xAA -> mem_done_o at N+2; RAM[0x20]=0x11AA3344. SH addr 0x23 data 0xBEEF -> 0xBEEF3344.
- SW then LW same address 0x30 with 0xCAFEF00D -> SW done N+1; LW granted N+2 and returns 0xCAFEF00D at N+3.
- Both ports held high for 3 accesses:
  - without the macro, grants are MEM, MEM, MEM and if_stall_o stays 1;
  - with DMEM_ARB_RR_EN, grants are MEM, IF, MEM.
- rst_i low during RMW of SB 0xFF at addr 0x40 (old 0x0) -> outputs 0 immediately; RAM[0x40] stays 0x00000000; after release, first request is granted in IDLE.
